// File: rtl/uart_pkg.sv
// Shared definitions for the arbitrated UART transmitter.
package uart_pkg;

    // Arbiter frame-control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    // Start bit + 8 data bits + stop bit.
    localparam int unsigned FRAME_BITS = 10;

    // Clock cycles spent on each serial bit.
    function automatic int unsigned bit_cycles(input int unsigned clock_hz, input int unsigned baud);
        return clock_hz / baud + 1;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 serializer: streams a frame while txen is held, restarting from the
// start bit whenever txen has been low. cts is high while a frame is in
// flight and drops during the final stop-bit cycle, so the controller can
// release txen exactly at the end of the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned Clock = 50000000,
    parameter int unsigned Baud  = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       txen,
    input  logic [7:0] data,
    output logic       txd,
    output logic       cts
);

    localparam int unsigned BIT_CYC = bit_cycles(Clock, Baud);
    localparam int unsigned CNT_W   = $clog2(BIT_CYC);
    localparam int unsigned IDX_W   = $clog2(FRAME_BITS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bit_end_c;
    logic             last_c;
    logic [FRAME_BITS-1:0] frame_c;

    assign bit_end_c = (cnt_q == CNT_W'(BIT_CYC - 1));
    assign last_c    = bit_end_c && (idx_q == IDX_W'(FRAME_BITS - 1));
    assign frame_c   = {1'b1, data, 1'b0};

    // Line level and frame-in-flight indication.
    assign txd = txen ? frame_c[idx_q] : 1'b1;
    assign cts = txen & ~last_c;

    // Bit-period and bit-index counters; cleared whenever txen is low.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!txen) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (bit_end_c) begin
            cnt_d = '0;
            idx_d = last_c ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding N byte requesters into one UART serializer.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned Clock = 50000000,
    parameter int unsigned Baud  = 9600,
    parameter int unsigned N     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [8*N-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    output logic                 txd,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [15:0]          frames_sent
);

    localparam int unsigned GNT_W = $clog2(N);

    arb_state_e       state_q, state_d;
    logic [GNT_W-1:0] ptr_q, ptr_d;
    logic [GNT_W-1:0] grant_q, grant_d;
    logic [7:0]       hold_q, hold_d;
    logic [15:0]      frames_sent_q, frames_sent_d;
    logic             busy_q, busy_d;
    logic             cts_prev_q;
    logic [1:0]       sync_q;

    logic [7:0]       req_bytes [N];
    logic [GNT_W-1:0] cand_c;
    logic [GNT_W-1:0] pick_idx_c;
    logic             pick_found_c;
    logic             accept_c;
    logic             txen_c;
    logic             ser_txd;
    logic             ser_cts;

    // Single serializer shared by all requesters.
    uart_tx #(
        .Clock (Clock),
        .Baud  (Baud)
    ) u_ser (
        .clock (clock),
        .reset (reset),
        .txen  (txen_c),
        .data  (hold_q),
        .txd   (ser_txd),
        .cts   (ser_cts)
    );

    // Split the flat request bus into per-requester bytes.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            req_bytes[i] = req_data[8*i +: 8];
        end
    end

    // First valid requester at or after ptr, searching cyclically.
    always_comb begin
        cand_c       = '0;
        pick_idx_c   = '0;
        pick_found_c = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            cand_c = GNT_W'((32'(ptr_q) + k) % N);
            if (!pick_found_c && req_valid[cand_c]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = cand_c;
            end
        end
    end

    // Acceptance only once reset release has crossed the synchronizer.
    assign accept_c = (state_q == ST_IDLE) && sync_q[1] && pick_found_c;

    // Next-state, handshake and datapath updates.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        hold_d        = hold_q;
        frames_sent_d = frames_sent_q;
        req_ready     = '0;
        txen_c        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    req_ready[pick_idx_c] = 1'b1;
                    hold_d  = req_bytes[pick_idx_c];
                    grant_d = pick_idx_c;
                    ptr_d   = (pick_idx_c == GNT_W'(N - 1)) ? '0 : pick_idx_c + GNT_W'(1);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                txen_c = 1'b1;
                if (cts_prev_q && !ser_cts) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                frames_sent_d = frames_sent_q + 16'd1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            hold_q        <= '0;
            frames_sent_q <= '0;
            busy_q        <= 1'b0;
            cts_prev_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            hold_q        <= hold_d;
            frames_sent_q <= frames_sent_d;
            busy_q        <= busy_d;
            cts_prev_q    <= ser_cts;
        end
    end

    // Two-stage reset-release synchronizer gating acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    // Line forced idle outside SEND so reset or drain never glitches a frame.
    assign txd         = (state_q == ST_SEND) ? ser_txd : 1'b1;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at 17 clocks per bit.
module tb_uart_tx_arbiter;

    localparam int unsigned N          = 4;
    localparam int unsigned BIT_T      = 17;
    localparam int unsigned WAIT_LIMIT = 400;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           txd;
    logic           busy;
    logic [1:0]     grant_id;
    logic [15:0]    frames_sent;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    uart_tx_arbiter #(
        .Clock (16),
        .Baud  (1),
        .N     (N)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .txd         (txd),
        .busy        (busy),
        .grant_id    (grant_id),
        .frames_sent (frames_sent)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Wait (bounded) until some req_ready is high; returns cycles waited.
    task automatic wait_ready(output int unsigned waited);
        waited = 0;
        #1;
        while (req_ready == '0 && waited < WAIT_LIMIT) begin
            @(negedge clock);
            #1;
            waited++;
        end
        check_eq("ready_within_bound", 32'(waited < WAIT_LIMIT), 32'd1);
    endtask

    // Called in the acceptance cycle; checks the whole frame and returns in
    // the idle cycle following DRAIN.
    task automatic send_check(input int unsigned idx, input logic [7:0] b, input bit drop);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        check_eq("accept_onehot", 32'(req_ready), 32'(1) << idx);
        check_eq("txd_idle_at_accept", 32'(txd), 32'd1);
        @(negedge clock);
        if (drop) req_valid = '0;
        check_eq("grant_id", 32'(grant_id), idx);
        check_eq("busy_in_send", 32'(busy), 32'd1);
        repeat (8) @(negedge clock);
        for (int k = 0; k < 10; k++) begin
            check_eq($sformatf("txd_bit%0d", k), 32'(txd), 32'(fr[4'(k)]));
            if (k < 9) repeat (BIT_T) @(negedge clock);
        end
        repeat (9) @(negedge clock);
        check_eq("txd_drain", 32'(txd), 32'd1);
        check_eq("busy_drain", 32'(busy), 32'd1);
        check_eq("ready_drain", 32'(req_ready), 32'd0);
        @(negedge clock);
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("txd_gap", 32'(txd), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned w;
        int unsigned ord [5];
        logic [7:0]  bytes [5];

        // Reset state, with a request already pending.
        reset     = 1'b0;
        req_valid = 4'b0001;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h55};
        repeat (3) @(negedge clock);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_txd", 32'(txd), 32'd1);
        check_eq("rst_frames", 32'(frames_sent), 32'd0);
        check_eq("rst_grant", 32'(grant_id), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("ready_release_cycle", 32'(req_ready), 32'd0);
        @(negedge clock);
        #1;
        check_eq("ready_first_cycle_after_release", 32'(req_ready), 32'd0);

        // Single request, 0x55.
        wait_ready(w);
        send_check(0, 8'h55, 1'b1);
        check_eq("frames_single", 32'(frames_sent), 32'd1);
        repeat (5) @(negedge clock);
        check_eq("no_spurious_busy", 32'(busy), 32'd0);
        check_eq("no_spurious_ready", 32'(req_ready), 32'd0);

        // All requesters held: 0,1,2,3,0 back to back.
        req_valid = '0;
        do_reset();
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        ord   = '{0, 1, 2, 3, 0};
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        for (int i = 0; i < 5; i++) begin
            wait_ready(w);
            if (i > 0) check_eq("back_to_back_wait", w, 32'd0);
            send_check(ord[i], bytes[i], i == 4);
        end
        check_eq("frames_all", 32'(frames_sent), 32'd5);

        // Fairness with requesters 0 and 2 only.
        do_reset();
        req_data  = {8'hEE, 8'h3C, 8'hDD, 8'hA5};
        req_valid = 4'b0101;
        ord   = '{0, 2, 0, 2, 0};
        bytes = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
        for (int i = 0; i < 4; i++) begin
            wait_ready(w);
            if (i > 0) check_eq("fair_wait", w, 32'd0);
            send_check(ord[i], bytes[i], i == 3);
        end
        check_eq("frames_fair", 32'(frames_sent), 32'd4);

        // Requester 1 becomes valid mid-frame of requester 0.
        req_data  = {8'h00, 8'h00, 8'h00, 8'h5A};
        req_valid = 4'b0001;
        wait_ready(w);
        fork
            send_check(0, 8'h5A, 1'b1);
            begin
                repeat (50) @(negedge clock);
                req_data[15:8] = 8'hC3;
                req_valid[1]   = 1'b1;
            end
        join
        wait_ready(w);
        check_eq("late_valid_next_cycle", w, 32'd0);
        send_check(1, 8'hC3, 1'b1);
        check_eq("frames_late", 32'(frames_sent), 32'd6);

        // Reset 60 cycles into a frame.
        req_data[7:0] = 8'hF0;
        req_valid     = 4'b0001;
        wait_ready(w);
        check_eq("abort_accept", 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid = '0;
        repeat (59) @(negedge clock);
        check_eq("abort_pre_txd", 32'(txd), 32'd0);
        check_eq("abort_pre_busy", 32'(busy), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("abort_txd", 32'(txd), 32'd1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_frames", 32'(frames_sent), 32'd0);
        check_eq("abort_ready", 32'(req_ready), 32'd0);
        req_data[7:0] = 8'h0F;
        req_valid     = 4'b0001;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("abort_release_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        #1;
        check_eq("abort_after_release_ready", 32'(req_ready), 32'd0);
        check_eq("abort_after_release_frames", 32'(frames_sent), 32'd0);
        wait_ready(w);
        send_check(0, 8'h0F, 1'b1);
        check_eq("frames_after_abort", 32'(frames_sent), 32'd1);

        // Counter wrap from 0xFFFF.
        req_valid = '0;
        @(negedge clock);
        force dut.frames_sent_q = 16'hFFFF;
        @(negedge clock);
        release dut.frames_sent_q;
        #1;
        check_eq("frames_preload", 32'(frames_sent), 32'h0000FFFF);
        req_data[15:8] = 8'h81;
        req_valid      = 4'b0010;
        wait_ready(w);
        send_check(1, 8'h81, 1'b1);
        check_eq("frames_wrap", 32'(frames_sent), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
